// File: rtl/channel_write_arbiter.sv
// Round-robin arbiter sharing one channel write port among NPORTS producers.
// Optional grant timeout is enabled by defining CHANNEL_ARB_TIMEOUT_EN.
module channel_write_arbiter #(
    parameter int NPORTS  = 4,
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 8,
    localparam int IW     = (NPORTS > 1) ? $clog2(NPORTS) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NPORTS-1:0]         req,
    input  logic [NPORTS*WIDTH-1:0]   req_in_data,
    input  logic [NPORTS-1:0]         req_write_valid,
    output logic [NPORTS-1:0]         req_write_ready,
    output logic [WIDTH-1:0]          out_in_data,
    output logic                      out_write_valid,
    input  logic                      out_write_ready,
    output logic [IW-1:0]             grant_id,
    output logic                      busy
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_SEND  = 2'd2;

    logic [1:0]       state_r, state_s;
    logic [IW-1:0]    ptr_r, ptr_s;
    logic [IW-1:0]    grant_id_r, grant_id_s;
    logic [WIDTH-1:0] hold_data_r, hold_data_s;
    logic             sel_valid_s;
    logic [IW-1:0]    sel_id_s;
    logic [IW-1:0]    cand_s;
`ifdef CHANNEL_ARB_TIMEOUT_EN
    logic [7:0]       timer_r, timer_s;
`endif

    // Port index base+off, wrapped modulo NPORTS (off < NPORTS).
    function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int off);
        int t;
        t = int'(base) + off;
        return IW'((t >= NPORTS) ? t - NPORTS : t);
    endfunction

    // Port after p, wrapping to 0.
    function automatic logic [IW-1:0] next_port(input logic [IW-1:0] p);
        return wrap_add(p, 1);
    endfunction

    // First requesting port at or after ptr.
    always_comb begin
        sel_valid_s = 1'b0;
        sel_id_s    = '0;
        cand_s      = '0;
        for (int i = 0; i < NPORTS; i++) begin
            cand_s = wrap_add(ptr_r, i);
            if (!sel_valid_s && req[cand_s]) begin
                sel_valid_s = 1'b1;
                sel_id_s    = cand_s;
            end else begin
                sel_valid_s = sel_valid_s;
            end
        end
    end

    // Next-state logic for the IDLE/GRANT/SEND controller.
    always_comb begin
        state_s     = state_r;
        ptr_s       = ptr_r;
        grant_id_s  = grant_id_r;
        hold_data_s = hold_data_r;
`ifdef CHANNEL_ARB_TIMEOUT_EN
        timer_s     = timer_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (out_write_ready && sel_valid_s) begin
                    state_s    = ST_GRANT;
                    grant_id_s = sel_id_s;
`ifdef CHANNEL_ARB_TIMEOUT_EN
                    timer_s    = 8'd0;
`endif
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_GRANT: begin
                // A write pulse wins over the request dropping or a timeout.
                if (req_write_valid[grant_id_r]) begin
                    hold_data_s = req_in_data[grant_id_r*WIDTH +: WIDTH];
                    state_s     = ST_SEND;
                end else if (!req[grant_id_r]) begin
                    ptr_s   = next_port(grant_id_r);
                    state_s = ST_IDLE;
`ifdef CHANNEL_ARB_TIMEOUT_EN
                end else if (timer_r == 8'(TIMEOUT - 1)) begin
                    ptr_s   = next_port(grant_id_r);
                    state_s = ST_IDLE;
                end else begin
                    timer_s = timer_r + 8'd1;
                end
`else
                end else begin
                    state_s = ST_GRANT;
                end
`endif
            end
            ST_SEND: begin
                if (out_write_ready) begin
                    ptr_s   = next_port(grant_id_r);
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_SEND;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            ptr_r       <= '0;
            grant_id_r  <= '0;
            hold_data_r <= '0;
`ifdef CHANNEL_ARB_TIMEOUT_EN
            timer_r     <= 8'd0;
`endif
        end else begin
            state_r     <= state_s;
            ptr_r       <= ptr_s;
            grant_id_r  <= grant_id_s;
            hold_data_r <= hold_data_s;
`ifdef CHANNEL_ARB_TIMEOUT_EN
            timer_r     <= timer_s;
`endif
        end
    end

    // Output decode; out_write_ready is the only input reaching an output.
    always_comb begin
        if (state_r == ST_GRANT) begin
            req_write_ready = NPORTS'(1) << grant_id_r;
        end else begin
            req_write_ready = '0;
        end
        if (state_r == ST_SEND) begin
            out_in_data     = hold_data_r;
            out_write_valid = out_write_ready;
        end else begin
            out_in_data     = '0;
            out_write_valid = 1'b0;
        end
        grant_id = grant_id_r;
        busy     = (state_r != ST_IDLE);
    end

endmodule

// File: doc/channel_write_arbiter.md
# channel_write_arbiter

Round-robin arbiter that shares one downstream channel write port among `NPORTS` HLS-generated producer blocks, such as several reduce kernels writing results into a single FIFO channel. It presents each producer with a private channel-style write interface (`write_ready` out, `write_valid`/`in_data` in), grants one producer at a time, and captures that producer's single-cycle write pulse. It then replays the captured word onto the shared channel only when the channel is ready, so no write is lost under backpressure.

## Interface
- `NPORTS`, default 4: number of producer ports, 2..16.
- `WIDTH`, default 32: data word width.
- `TIMEOUT`, default 8: maximum GRANT cycles without `write_valid` before the grant is abandoned (only with `CHANNEL_ARB_TIMEOUT_EN`).

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req` in NPORTS: level request per producer; the producer holds it high while it has a word to write.
- `req_in_data` in NPORTS*WIDTH: packed data; port i occupies bits [i*WIDTH +: WIDTH].
- `req_write_valid` in NPORTS: single-cycle write pulse per producer.
- `req_write_ready` out NPORTS: one-hot grant; at most one bit set.
- `out_in_data` out WIDTH: data to the shared channel.
- `out_write_valid` out 1: write strobe to the shared channel.
- `out_write_ready` in 1: shared channel can accept a write.
- `grant_id` out clog2(NPORTS): index of the current or last granted port.
- `busy` out 1: high whenever the state is not IDLE.

## Operation
- **State machine states:** IDLE, GRANT, SEND.
- **IDLE**
  - If `out_write_ready` is high and any `req` bit is set, select the first requesting port at or after `ptr`, wrapping modulo NPORTS.
  - Latch the selection into `grant_id` and go to GRANT.
  - Otherwise stay in IDLE.
- **GRANT**
  - `req_write_ready[grant_id]` = 1.
  - If `req_write_valid[grant_id]` is high: latch `req_in_data` slice into `hold_data` and go to SEND.
  - Else, if `req[grant_id]` is low: abandon the grant, set `ptr` = `grant_id`+1, go to IDLE.
  - `write_valid` takes priority over `req` dropping in the same cycle.
- **SEND**
  - `out_in_data` = `hold_data`.
  - `out_write_valid` = `out_write_ready`, combinational.
  - When `out_write_ready` is high, the transfer completes: set `ptr` = `grant_id`+1 mod NPORTS and go to IDLE.
  - When `out_write_ready` is low, stay in SEND with `out_write_valid` low.
- **Ignored inputs:** `req_write_valid` on non-granted ports, and in IDLE or SEND, has no effect.
- **Reset values:** state IDLE, `ptr` 0, `grant_id` 0, `hold_data` 0, `req_write_ready` 0, `out_write_valid` 0, `out_in_data` 0, `busy` 0.
- **Reset mid-operation:** asserting `rst` in any state discards the held word. Outputs return to reset values immediately, asynchronously.

## Timing
- **Request to grant:** `req[i]` sampled high at edge k, with `out_write_ready` high and the arbiter idle, gives `req_write_ready[i]` high from cycle k+1.
- **Capture:** a producer pulse at cycle k+2 (one cycle after it sees ready) is captured at edge k+3.
- **Output:** `out_write_valid` rises at cycle k+3 if `out_write_ready` is high.
- **Latency:** request to output is 3 cycles minimum.
- **Throughput:** one word per 4 cycles minimum.
- **Fairness:** a continuously requesting port waits at most NPORTS−1 grants.
- **Output decode:** all outputs are combinational decodes of registered state and `out_write_ready`. No input-to-output path exists except `out_write_ready` → `out_write_valid`.

## Configuration
- **`CHANNEL_ARB_TIMEOUT_EN` defined:**
  - An 8-bit counter clears on entry to GRANT and increments each GRANT cycle.
  - At count == TIMEOUT−1 with no `write_valid`, the grant is abandoned: `ptr` = `grant_id`+1, go to IDLE.
  - `write_valid` in that same cycle still wins.
- **`CHANNEL_ARB_TIMEOUT_EN` not defined:** no counter; GRANT is left only via `write_valid` or `req` dropping.

## Test plan
- **Single request:** `req`=4'b0001, producer pulses valid with 0xDEADBEEF one cycle after ready → single `out_write_valid` pulse with `out_in_data`=0xDEADBEEF, 3 cycles after `req`; `busy` then low.
- **Round-robin:** `req`=4'b1111 held, each producer writes its own port index → output sequence 0,1,2,3,0; `req_write_ready` always one-hot.
- **Backpressure:** `out_write_ready` forced low for 5 cycles while in SEND with 0x12345678 → `out_write_valid` stays 0; word emitted exactly once when ready rises; no other port granted meanwhile.
- **Abandon:** port 2 granted, `req[2]` drops with no valid → IDLE next cycle; with `req`=4'b1000 pending, port 3 granted; nothing emitted for port 2.
- **Timeout (macro on, TIMEOUT=8):** granted port never pulses valid → grant released after 8 GRANT cycles and `ptr` advanced. With the macro off, the grant is held indefinitely.
- **Async reset in SEND with 0xCAFEF00D held:** `out_write_valid`, `req_write_ready` and `busy` drop immediately; after release, the first grant goes to the lowest requesting index and 0xCAFEF00D is never emitted.
